// File: rtl/sb_enc_pkg.sv
// Shared definitions for the sideband TX data encoder: LTSM codes, result
// message numbers and the message-to-payload encoding function.
package sb_enc_pkg;

  localparam logic [3:0] ST_MBINIT = 4'd3;
  localparam logic [3:0] ST_ACTIVE = 4'd6;

  localparam logic [3:0] SUB_PARAM      = 4'd0;
  localparam logic [3:0] SUB_REVERSALMB = 4'd4;

  localparam logic [1:0] MODE_TX_POINT = 2'd0;
  localparam logic [1:0] MODE_TX_EYE   = 2'd1;
  localparam logic [1:0] MODE_RX_POINT = 2'd2;
  localparam logic [1:0] MODE_RX_EYE   = 2'd3;

  localparam logic [3:0] MSG_TEST_REQ        = 4'd1;
  localparam logic [3:0] MSG_REVERSAL_RESULT = 4'd6;
  localparam logic [3:0] RES_MSG_POINT       = 4'd6;
  localparam logic [3:0] RES_MSG_RX_EYE      = 4'd9;

  localparam int ENTRY_W = 65;

  typedef enum logic [1:0] {
    ENC_PUSH   = 2'd0,
    ENC_IGNORE = 2'd1,
    ENC_DROP   = 2'd2
  } enc_action_e;

  typedef struct packed {
    enc_action_e action;
    logic        has_data;
    logic [63:0] payload;
  } enc_result_t;

  // TX eye sweep has no result message, so it never matches.
  function automatic logic is_result_msg(input logic [1:0] test_mode,
                                         input logic [3:0] msg_no);
    logic hit;
    hit = 1'b0;
    case (test_mode)
      MODE_TX_POINT, MODE_RX_POINT: hit = (msg_no == RES_MSG_POINT);
      MODE_RX_EYE:                  hit = (msg_no == RES_MSG_RX_EYE);
      default:                      hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic enc_result_t sb_enc_payload(input logic        rdi,
                                                 input logic        test_en,
                                                 input logic        data_valid,
                                                 input logic [1:0]  test_mode,
                                                 input logic [3:0]  state,
                                                 input logic [3:0]  sub_state,
                                                 input logic [3:0]  msg_no,
                                                 input logic [63:0] data);
    enc_result_t r;
    r.action   = ENC_PUSH;
    r.has_data = 1'b0;
    r.payload  = '0;
    if (!rdi) begin
      if (test_en && data_valid) begin
        if (msg_no == MSG_TEST_REQ) begin
          r.payload[0]     = data[0];
          r.payload[7:6]   = data[2:1];
          r.payload[11]    = data[3];
          r.payload[58:43] = 16'hFFFF;
          r.payload[59]    = data[4];
          r.has_data       = 1'b1;
        end else if (is_result_msg(test_mode, msg_no)) begin
          r.payload  = data;
          r.has_data = 1'b1;
        end
      end else if (data_valid && (msg_no == 4'd0)) begin
        r.action = ENC_IGNORE;
      end else if ((state == ST_MBINIT) && (sub_state == SUB_PARAM)) begin
        r.payload[10:0] = data[10:0];
        r.has_data      = 1'b1;
      end else if ((state == ST_MBINIT) && (sub_state == SUB_REVERSALMB) &&
                   (msg_no == MSG_REVERSAL_RESULT)) begin
        r.payload[15:0] = data[15:0];
        r.has_data      = 1'b1;
      end else if (data_valid) begin
        r.action = ENC_DROP;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sb_tx_enc_fifo.sv
// Generic synchronous FIFO with an explicit occupancy counter; the head is
// presented combinationally from registered state and reads as zero when empty.
module sb_tx_enc_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap without compare logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sb_tx_data_encoder_q.sv
// Sideband TX data encoder: encodes LTSM/RDI message requests into a 64-bit
// payload plus has-data flag and queues them towards packet framing.
module sb_tx_data_encoder_q
  import sb_enc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_msg_valid,
  output logic              o_msg_ready,
  input  logic              i_data_valid,
  input  logic [3:0]        i_state,
  input  logic [3:0]        i_sub_state,
  input  logic [3:0]        i_msg_no,
  input  logic [DATA_W-1:0] i_data_bus,
  input  logic              i_test_en,
  input  logic [1:0]        i_test_mode,
  input  logic              i_rdi_msg,
  output logic              o_d_valid,
  input  logic              i_d_ready,
  output logic [63:0]       o_data_encoded,
  output logic              o_has_data,
  output logic              o_drop,
  output logic [LVL_W-1:0]  o_level
);

  logic [63:0]        data_ext;
  enc_result_t        enc;
  logic               full;
  logic               empty;
  logic               accept;
  logic               push;
  logic               drop_next;
  logic [ENTRY_W-1:0] head;

  assign data_ext = 64'(i_data_bus);
  assign enc = sb_enc_payload(i_rdi_msg, i_test_en, i_data_valid, i_test_mode,
                              i_state, i_sub_state, i_msg_no, data_ext);

  // A request against a full queue is rejected even if the head pops this cycle.
  assign accept    = i_msg_valid && !full;
  assign push      = accept && (enc.action == ENC_PUSH);
  assign drop_next = i_msg_valid && (full || (enc.action == ENC_DROP));

  sb_tx_enc_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (push),
    .push_data ({enc.has_data, enc.payload}),
    .pop       (i_d_ready),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (o_level)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_drop <= 1'b0;
    end else begin
      o_drop <= drop_next;
    end
  end

  assign o_msg_ready    = !full;
  assign o_d_valid      = !empty;
  assign o_has_data     = head[64];
  assign o_data_encoded = head[63:0];

endmodule

// File: tb/tb_sb_tx_data_encoder_q.sv
// Randomized scoreboard bench for sb_tx_data_encoder_q with a behavioural
// reference model of the encoding rules and queue occupancy.
module tb_sb_tx_data_encoder_q;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_msg_valid;
  logic              o_msg_ready;
  logic              i_data_valid;
  logic [3:0]        i_state;
  logic [3:0]        i_sub_state;
  logic [3:0]        i_msg_no;
  logic [DATA_W-1:0] i_data_bus;
  logic              i_test_en;
  logic [1:0]        i_test_mode;
  logic              i_rdi_msg;
  logic              o_d_valid;
  logic              i_d_ready;
  logic [63:0]       o_data_encoded;
  logic              o_has_data;
  logic              o_drop;
  logic [LVL_W-1:0]  o_level;

  always #5 i_clk = ~i_clk;

  sb_tx_data_encoder_q #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_msg_valid    (i_msg_valid),
    .o_msg_ready    (o_msg_ready),
    .i_data_valid   (i_data_valid),
    .i_state        (i_state),
    .i_sub_state    (i_sub_state),
    .i_msg_no       (i_msg_no),
    .i_data_bus     (i_data_bus),
    .i_test_en      (i_test_en),
    .i_test_mode    (i_test_mode),
    .i_rdi_msg      (i_rdi_msg),
    .o_d_valid      (o_d_valid),
    .i_d_ready      (i_d_ready),
    .o_data_encoded (o_data_encoded),
    .o_has_data     (o_has_data),
    .o_drop         (o_drop),
    .o_level        (o_level)
  );

  typedef struct packed {
    bit        mv;
    bit        dv;
    bit        te;
    bit [1:0]  mode;
    bit        rdi;
    bit [3:0]  state;
    bit [3:0]  sub;
    bit [3:0]  msg_no;
    bit [63:0] d;
    bit        dr;
  } req_t;

  logic [64:0] exp_q[$];
  int          model_level = 0;
  bit          exp_drop = 1'b0;
  bit          checking = 1'b0;
  int          compared = 0;
  int          mismatched = 0;

  function automatic req_t mk(bit mv, bit dv, bit te, bit [1:0] mode, bit rdi,
                              bit [3:0] state, bit [3:0] sub, bit [3:0] msg_no,
                              bit [63:0] d, bit dr);
    req_t r;
    r.mv = mv; r.dv = dv; r.te = te; r.mode = mode; r.rdi = rdi;
    r.state = state; r.sub = sub; r.msg_no = msg_no; r.d = d; r.dr = dr;
    return r;
  endfunction

  // Reference encoding written straight from the message rules.
  function automatic void model(input req_t r, output bit keep, output bit reject,
                                output logic [64:0] entry);
    logic [63:0] d;
    int          res_no;
    d      = r.d;
    keep   = 1'b1;
    reject = 1'b0;
    entry  = '0;
    res_no = (r.mode == 2'd1) ? -1 : ((r.mode == 2'd3) ? 9 : 6);
    if (r.rdi) return;
    if (r.dv && r.te) begin
      if (r.msg_no == 4'd1)
        entry = {1'b1, (d & 64'd1) | (((d >> 1) & 64'd3) << 6) | (((d >> 3) & 64'd1) << 11) |
                       (64'hFFFF << 43) | (((d >> 4) & 64'd1) << 59)};
      else if (int'(r.msg_no) == res_no)
        entry = {1'b1, d};
    end else if (r.dv) begin
      if (r.msg_no == 4'd0)
        keep = 1'b0;
      else if (r.state == 4'd3 && r.sub == 4'd0)
        entry = {1'b1, d % 64'd2048};
      else if (r.state == 4'd3 && r.sub == 4'd4 && r.msg_no == 4'd6)
        entry = {1'b1, d % 64'd65536};
      else begin
        keep   = 1'b0;
        reject = 1'b1;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, required, $time);
    end
  endtask

  // Drives one cycle of inputs, predicts the queue effect of the next edge.
  task automatic applyStimulus(input req_t r);
    bit          keep;
    bit          reject;
    bit          accept;
    logic [64:0] entry;
    int          lvl_before;
    #1;
    i_msg_valid  = r.mv;
    i_data_valid = r.dv;
    i_test_en    = r.te;
    i_test_mode  = r.mode;
    i_rdi_msg    = r.rdi;
    i_state      = r.state;
    i_sub_state  = r.sub;
    i_msg_no     = r.msg_no;
    i_data_bus   = r.d[DATA_W-1:0];
    i_d_ready    = r.dr;
    model(r, keep, reject, entry);
    lvl_before = model_level;
    accept     = r.mv && (lvl_before != DEPTH);
    if (accept && keep) exp_q.push_back(entry);
    @(posedge i_clk);
    model_level = lvl_before + ((accept && keep) ? 1 : 0) - ((lvl_before != 0 && r.dr) ? 1 : 0);
    exp_drop    = r.mv && ((lvl_before == DEPTH) || reject);
  endtask

  task automatic idle(input bit dr, input int n);
    for (int i = 0; i < n; i++) applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, dr));
  endtask

  initial begin : monitor
    logic [64:0] e;
    forever begin
      @(negedge i_clk);
      if (checking && !i_rst) begin
        checkOutput("level", 64'(o_level), 64'(model_level));
        checkOutput("msg_ready", 64'(o_msg_ready), 64'(model_level != DEPTH));
        checkOutput("d_valid", 64'(o_d_valid), 64'(model_level != 0));
        checkOutput("drop", 64'(o_drop), 64'(exp_drop));
        if (o_d_valid && i_d_ready) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_entry: got %0h, expected no entry", o_data_encoded);
          end else begin
            e = exp_q.pop_front();
            checkOutput("payload", o_data_encoded, e[63:0]);
            checkOutput("has_data", 64'(o_has_data), 64'(e[64]));
          end
        end
      end
    end
  end

  initial begin : stimulus
    req_t r;
    bit   stall;
    i_rst = 1'b1;
    i_msg_valid = 0; i_data_valid = 0; i_test_en = 0; i_test_mode = 0; i_rdi_msg = 0;
    i_state = 0; i_sub_state = 0; i_msg_no = 0; i_data_bus = 0; i_d_ready = 0;
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("rst_d_valid", 64'(o_d_valid), 64'd0);
    checkOutput("rst_payload", o_data_encoded, 64'd0);
    checkOutput("rst_has_data", 64'(o_has_data), 64'd0);
    checkOutput("rst_drop", 64'(o_drop), 64'd0);
    checkOutput("rst_level", 64'(o_level), 64'd0);
    checkOutput("rst_msg_ready", 64'(o_msg_ready), 64'd1);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    checking = 1'b1;

    applyStimulus(mk(1, 1, 0, 0, 0, 3, 0, 2, 64'h07FF, 1));
    idle(1, 2);
    applyStimulus(mk(1, 1, 1, 0, 0, 0, 0, 1, 64'h1F, 1));
    applyStimulus(mk(1, 1, 1, 3, 0, 0, 0, 9, 64'hBEEF, 1));
    idle(1, 2);
    for (int i = 0; i < 5; i++) applyStimulus(mk(1, 1, 0, 0, 0, 3, 0, 4'(i + 1), 64'(100 + i), 0));
    idle(0, 1);
    idle(1, 5);
    applyStimulus(mk(1, 1, 0, 0, 0, 6, 0, 3, 64'h55, 1));
    applyStimulus(mk(1, 1, 0, 0, 0, 6, 0, 0, 64'h55, 1));
    idle(1, 2);
    applyStimulus(mk(1, 1, 0, 0, 0, 3, 4, 6, 64'h1111, 0));
    applyStimulus(mk(1, 1, 0, 0, 0, 3, 4, 6, 64'h2222, 0));
    applyStimulus(mk(1, 1, 1, 2, 0, 0, 0, 6, 64'hDEADBEEF, 1));
    idle(0, 1);
    applyStimulus(mk(1, 1, 0, 0, 1, 3, 0, 2, 64'hFFFF, 1));
    applyStimulus(mk(1, 1, 1, 1, 0, 0, 0, 6, 64'h1234, 1));
    applyStimulus(mk(1, 1, 0, 0, 0, 3, 4, 6, 64'h12345678, 1));
    idle(1, 5);

    for (int i = 0; i < 3; i++) applyStimulus(mk(1, 1, 0, 0, 0, 3, 0, 1, 64'(7 * i + 1), 0));
    idle(1, 1);
    #2 i_rst = 1'b1;
    #1;
    checkOutput("async_rst_d_valid", 64'(o_d_valid), 64'd0);
    checkOutput("async_rst_level", 64'(o_level), 64'd0);
    checkOutput("async_rst_msg_ready", 64'(o_msg_ready), 64'd1);
    exp_q.delete();
    model_level = 0;
    exp_drop = 1'b0;
    i_msg_valid = 1'b0;
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    applyStimulus(mk(1, 1, 0, 0, 0, 3, 0, 5, 64'hFFFF_FFFF, 1));
    idle(1, 2);

    stall = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) stall = ~stall;
      r.mv     = ($urandom % 10) < 7;
      r.dv     = ($urandom % 10) < 8;
      r.te     = ($urandom % 10) < 3;
      r.rdi    = ($urandom % 20) == 0;
      r.mode   = 2'($urandom);
      case ($urandom % 4)
        0, 1:    r.state = 4'd3;
        2:       r.state = 4'd6;
        default: r.state = 4'($urandom);
      endcase
      case ($urandom % 3)
        0:       r.sub = 4'd0;
        1:       r.sub = 4'd4;
        default: r.sub = 4'($urandom);
      endcase
      case ($urandom % 6)
        0:       r.msg_no = 4'd0;
        1:       r.msg_no = 4'd1;
        2:       r.msg_no = 4'd6;
        3:       r.msg_no = 4'd9;
        default: r.msg_no = 4'($urandom);
      endcase
      if (!r.dv && r.state == 4'd3) r.state = 4'd6;
      r.d  = 64'($urandom) & ((64'd1 << DATA_W) - 64'd1);
      r.dr = stall ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
      applyStimulus(r);
    end
    idle(1, DEPTH + 4);
    checkOutput("drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
